// File: rtl/am_sched.sv
// am_sched: alignment-marker slot scheduler shared by LANE_N PCS lanes.
// Each period is one marker slot followed by P-1 consumed data slots.
// P is AM_PERIOD, or TEST_PERIOD when test mode is selected. P is latched
// only on entry to a marker slot, so a test_i change mid-period takes effect
// from the next period.
module am_sched #(
  parameter int LANE_N      = 4,
  parameter int AM_PERIOD   = 16384,
  parameter int TEST_PERIOD = 16,
  localparam int CNT_W      = $clog2(AM_PERIOD)
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             en_i,
  input  logic             test_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             marker_v_o,
  output logic             pre_marker_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic [7:0]       am_cnt_o
);

  // Reject illegal parameter sets at elaboration time.
  generate
    if (LANE_N < 1 || AM_PERIOD < 4 || TEST_PERIOD < 4 || TEST_PERIOD > AM_PERIOD) begin : g_param_check
      $error("am_sched: illegal parameter set");
    end
  endgenerate

  // Last data-slot count value (P-2) for each period choice.
  localparam logic [CNT_W-1:0] AM_LIM   = CNT_W'(AM_PERIOD - 2);
  localparam logic [CNT_W-1:0] TEST_LIM = CNT_W'(TEST_PERIOD - 2);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MARK = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [7:0]       am_cnt_r, am_cnt_s;
  logic             test_sel_r, test_sel_s;
  logic             marker_r, ready_r, pre_r;

  // Map the latched period selection to its last data-slot count.
  function automatic logic [CNT_W-1:0] last_slot(input logic sel);
    logic [CNT_W-1:0] lim;
    if (sel) begin
      lim = TEST_LIM;
    end else begin
      lim = AM_LIM;
    end
    return lim;
  endfunction

  // Next-state, slot counter, marker counter and period latch.
  always_comb begin
    state_s    = state_r;
    cnt_s      = cnt_r;
    am_cnt_s   = am_cnt_r;
    test_sel_s = test_sel_r;
    case (state_r)
      IDLE: begin
        cnt_s = '0;
        if (en_i) begin
          state_s    = MARK;
          test_sel_s = test_i;
        end else begin
          state_s = IDLE;
        end
      end
      MARK: begin
        cnt_s    = '0;
        am_cnt_s = am_cnt_r + 8'd1;
        if (en_i) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (!en_i) begin
          // Partial period is discarded; re-enable restarts with a marker.
          state_s = IDLE;
          cnt_s   = '0;
        end else if (valid_i) begin
          if (cnt_r == last_slot(test_sel_r)) begin
            state_s    = MARK;
            cnt_s      = '0;
            test_sel_s = test_i;
          end else begin
            cnt_s = cnt_r + CNT_W'(1);
          end
        end else begin
          // Gaps do not consume slots.
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // State, counters and registered output decodes.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      am_cnt_r   <= 8'd0;
      test_sel_r <= 1'b0;
      marker_r   <= 1'b0;
      ready_r    <= 1'b0;
      pre_r      <= 1'b0;
    end else begin
      state_r    <= state_s;
      cnt_r      <= cnt_s;
      am_cnt_r   <= am_cnt_s;
      test_sel_r <= test_sel_s;
      marker_r   <= (state_s == MARK);
      ready_r    <= (state_s == RUN);
      pre_r      <= (state_s == RUN) && (cnt_s == last_slot(test_sel_s));
    end
  end

  assign marker_v_o   = marker_r;
  assign ready_o      = ready_r;
  assign pre_marker_o = pre_r;
  assign cnt_o        = cnt_r;
  assign am_cnt_o     = am_cnt_r;

endmodule

// File: tb/tb_am_sched.sv
// tb_am_sched: directed table plus hand sequences for am_sched (default params).
`timescale 1ns/1ps
module tb_am_sched;
  localparam int CNT_W = 14;

  logic             clk = 1'b0;
  logic             nreset;
  logic             en_i, test_i, valid_i;
  logic             ready_o, marker_v_o, pre_marker_o;
  logic [CNT_W-1:0] cnt_o;
  logic [7:0]       am_cnt_o;

  int checks   = 0;
  int failures = 0;

  am_sched dut (
    .clk          (clk),
    .nreset       (nreset),
    .en_i         (en_i),
    .test_i       (test_i),
    .valid_i      (valid_i),
    .ready_o      (ready_o),
    .marker_v_o   (marker_v_o),
    .pre_marker_o (pre_marker_o),
    .cnt_o        (cnt_o),
    .am_cnt_o     (am_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic en;
    logic test;
    logic valid;
    logic m;
    logic r;
    logic p;
    int   cnt;
    int   am;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  function automatic void push(input logic en, input logic test, input logic valid,
                               input logic m, input logic r, input logic p,
                               input int cnt, input int am);
    vec_t v;
    v.en = en; v.test = test; v.valid = valid;
    v.m = m; v.r = r; v.p = p; v.cnt = cnt; v.am = am;
    vecs.push_back(v);
  endfunction

  task automatic check_idle(input string nm);
    chk({nm, "_marker"}, {31'd0, marker_v_o}, 32'd0);
    chk({nm, "_ready"}, {31'd0, ready_o}, 32'd0);
    chk({nm, "_pre"}, {31'd0, pre_marker_o}, 32'd0);
    chk({nm, "_cnt"}, {18'd0, cnt_o}, 32'd0);
  endtask

  // Reset with all inputs low; release on a falling edge.
  task automatic do_reset();
    nreset = 1'b0; en_i = 1'b0; test_i = 1'b0; valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle("reset");
    chk("reset_am", {24'd0, am_cnt_o}, 32'd0);
    @(negedge clk);
    nreset = 1'b1;
  endtask

  initial begin
    int marker2, data, nmark, cyc, p0, p1, period_ok;
    logic switched;

    // Directed table: edge k uses inputs applied before it.
    for (int k = 1; k <= 18; k++) begin
      if (k == 1)       push(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0);
      else if (k <= 16) push(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, (k == 16), k - 2, 1);
      else if (k == 17) push(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 1);
      else              push(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 0, 2);
    end
    for (int k = 19; k <= 25; k++) push(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, k - 18, 2);
    push(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 2);  // en dropped at cnt 7
    push(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 2);
    push(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0, 2);  // re-enable: marker first
    push(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 3);  // en low during MARK
    push(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 3);
    push(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 4);
    push(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 4);

    do_reset();
    foreach (vecs[i]) begin
      en_i = vecs[i].en; test_i = vecs[i].test; valid_i = vecs[i].valid;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_marker", i), {31'd0, marker_v_o}, {31'd0, vecs[i].m});
      chk($sformatf("v%0d_ready", i), {31'd0, ready_o}, {31'd0, vecs[i].r});
      chk($sformatf("v%0d_pre", i), {31'd0, pre_marker_o}, {31'd0, vecs[i].p});
      chk($sformatf("v%0d_cnt", i), {18'd0, cnt_o}, vecs[i].cnt);
      chk($sformatf("v%0d_am", i), {24'd0, am_cnt_o}, vecs[i].am);
      chk($sformatf("v%0d_excl", i), {31'd0, marker_v_o & ready_o}, 32'd0);
    end

    // Five-cycle valid gap: cnt holds at 3, second marker at cycle 22.
    do_reset();
    en_i = 1'b1; test_i = 1'b1; marker2 = 0;
    for (int c = 1; c <= 30; c++) begin
      valid_i = !(c >= 6 && c <= 10);
      @(posedge clk);
      #1;
      if (c >= 6 && c <= 10) chk("gap_cnt_hold", {18'd0, cnt_o}, 32'd3);
      if (c > 1 && marker_v_o && marker2 == 0) marker2 = c;
    end
    chk("gap_marker_cycle", marker2, 32'd22);

    // Asynchronous reset during a marker slot.
    do_reset();
    en_i = 1'b1; test_i = 1'b1; valid_i = 1'b1;
    repeat (17) @(posedge clk);
    #1;
    chk("mark2_marker", {31'd0, marker_v_o}, 32'd1);
    chk("mark2_am", {24'd0, am_cnt_o}, 32'd1);
    #2;
    nreset = 1'b0;
    #1;
    check_idle("async_rst");
    chk("async_rst_am", {24'd0, am_cnt_o}, 32'd0);
    @(negedge clk);
    nreset = 1'b1; en_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check_idle("post_rst_idle");
    end
    en_i = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_marker", {31'd0, marker_v_o}, 32'd1);

    // Full-length period, then test_i switched mid-period at cnt 100.
    do_reset();
    en_i = 1'b1; test_i = 1'b0; valid_i = 1'b1;
    data = 0; nmark = 0; p0 = 0; p1 = 0; switched = 1'b0; cyc = 0;
    while (nmark < 3 && cyc < 40000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (marker_v_o) begin
        if (nmark == 1) p0 = data;
        if (nmark == 2) p1 = data;
        nmark++;
        data = 0;
      end else if (ready_o) begin
        data++;
      end
      if (!switched && ready_o && cnt_o == 14'd100) begin
        test_i = 1'b1;
        switched = 1'b1;
      end
    end
    chk("long_markers_seen", nmark, 32'd3);
    chk("long_period_slots", p0, 32'd16383);
    chk("test_period_slots", p1, 32'd15);

    // Random en/valid in test mode: P-1 consumed slots per complete period.
    do_reset();
    test_i = 1'b1; en_i = 1'b1; valid_i = 1'b1;
    period_ok = 0; data = 0;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      chk("rand_excl", {31'd0, marker_v_o & ready_o}, 32'd0);
      if (cnt_o > 14'd14) chk("rand_cnt_max", {18'd0, cnt_o}, 32'd14);
      if (marker_v_o) begin
        if (period_ok != 0) chk("rand_period_slots", data, 32'd15);
        period_ok = 1;
        data = 0;
      end else if (!ready_o) begin
        period_ok = 0;
      end
      en_i    = ($urandom_range(0, 99) < 97);
      valid_i = ($urandom_range(0, 3) != 0);
      if (ready_o && valid_i && en_i) data++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
